uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver paired with the existing `uartTx` transmitter. It deserialises an 8N1 asynchronous serial stream into bytes and holds each byte in a one-entry buffer with a valid/read handshake. The core reads the byte, or polls the status flags, through a memory-mapped register slot.

## Interface
Parameters:
- CLKS_PER_BIT, default 434. Clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.

Ports:
- clock  in  1  system clock; all logic updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- uartRxPin  in  1  serial line, idle high, asynchronous to clock
- buffer  out  8  last received byte
- valid  out  1  buffer holds an unread byte
- re  in  1  read strobe; one-cycle pulse acknowledges the byte
- frameErr  out  1  sticky flag: a stop bit was sampled low
- overrun  out  1  sticky flag: a byte arrived while valid was 1 and was not acknowledged

## Operation
- Input synchronisation:
  - uartRxPin passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses only the synchronised line `rxs`.
- Definitions:
  - HALF = CLKS_PER_BIT/2, truncated.
  - One cycle counter `cnt`, wide enough for CLKS_PER_BIT-1.
  - One 3-bit bit index `idx`.
  - One 8-bit shift register `sh`.
- State machine, one-hot or encoded; the state is not exported:
  - IDLE: cnt=0. When rxs=0, go to START.
  - START: cnt increments. At cnt==HALF-1, sample rxs.
    - rxs=0: go to DATA with cnt=0, idx=0.
    - rxs=1 (glitch): go to IDLE. No flags change.
  - DATA: cnt increments. At cnt==CLKS_PER_BIT-1, shift rxs into sh[7] (LSB first) and set cnt=0.
    - idx increments on each sample.
    - After the sample taken at idx==7, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - rxs=1: load buffer with sh, set valid=1, go to IDLE.
    - rxs=0: set frameErr=1, discard the byte, go to RECOVER.
  - RECOVER: wait for rxs=1, then go to IDLE. This prevents a break condition from being taken as back-to-back start bits.
- Handshake:
  - re=1 with valid=1 clears valid on the same edge.
  - re=1 clears frameErr and overrun regardless of valid.
  - re=0 leaves all flags unchanged.
- Byte completion while valid=1:
  - re=1 on that same edge: the new byte loads and valid stays 1. overrun is not set; re clears any earlier overrun.
  - re=0: the new byte overwrites buffer and overrun is set to 1.
- Set/clear collision:
  - frameErr or overrun set coincident with re: set wins.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; cnt, idx, sh = 0.
  - buffer=8'h00, valid=0, frameErr=0, overrun=0.
  - The partial frame is lost. Reception restarts only on the next falling edge seen after reset release. If the line is already low, a start is detected immediately; the bench must release reset with the line idle.

## Timing
- Pin to rxs latency: 2 cycles.
- e0 is the edge at which IDLE sees rxs=0.
  - Start validation sample: edge e0+HALF.
  - Data bit i sample (i=0..7): edge e0+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample: edge e0+HALF+9·CLKS_PER_BIT.
  - valid, buffer, frameErr become visible immediately after the stop-sample edge.
- Earliest next start detection is the cycle after the stop sample, so frames with a stop bit of exactly one bit time are accepted back-to-back.
- All outputs are registered; there are no combinational input→output paths.
- Baud tolerance: sampling is mid-bit, so ±4% cumulative clock mismatch is tolerated.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Single byte: send 8'hA5 with a good stop bit.
  - valid rises at e0+8+144 with buffer=8'hA5, frameErr=0.
  - Pulse re: valid=0 on the next cycle.
- Back-to-back: send 8'h00, 8'hFF, 8'h55 with no idle gap, re pulsed after each byte.
  - Three valid pulses with the correct bytes; overrun=0 throughout.
- Overrun: send 8'h12 then 8'h34 without re.
  - buffer=8'h34, valid=1, overrun=1.
  - re clears valid and overrun together.
- Framing error: send 8'h3C with the stop bit held low for 3 bit times, then idle high.
  - frameErr=1, valid=0, buffer unchanged.
  - A following 8'h7E is received correctly.
- Glitch: 4-cycle low pulse on uartRxPin.
  - FSM returns to IDLE; valid, frameErr and overrun stay 0.
- Reset mid-frame: assert reset during data bit 3 of 8'hC3 with valid=1 from an earlier byte.
  - All outputs go to 0 immediately and asynchronously.
  - After reset release with the line idle, the next byte 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-entry byte buffer and sticky status flags
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uartRxPin,
  output logic [7:0] buffer,
  output logic       valid,
  input  logic       re,
  output logic       frameErr,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    buffer_q, buffer_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          byte_done, stop_bad;
  logic          rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        // A held-low line (break) must return high before a new start is accepted.
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Set terms take priority over the read-strobe clear.
  always_comb begin
    buffer_d    = byte_done ? sh_q : buffer_q;
    valid_d     = byte_done | (valid_q & ~re);
    overrun_d   = (byte_done & valid_q & ~re) | (overrun_q & ~re);
    frame_err_d = stop_bad | (frame_err_q & ~re);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sh_q        <= 8'h00;
      buffer_q    <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= uartRxPin;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      buffer_q    <= buffer_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign buffer   = buffer_q;
  assign valid    = valid_q;
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT=16
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       uartRxPin;
  logic [7:0] buffer;
  logic       valid;
  logic       re;
  logic       frameErr;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       ovr;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .uartRxPin(uartRxPin), .buffer(buffer),
    .valid(valid), .re(re), .frameErr(frameErr), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic ovr, input logic fe);
    exp_t e;
    e.d = d; e.ovr = ovr; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic bit_time(input logic v, input int n);
    uartRxPin = v;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input int stop_low);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(b[i], 1);
    if (stop_low > 0) begin
      bit_time(1'b0, stop_low);
      bit_time(1'b1, 2);
    end else begin
      bit_time(1'b1, 1);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({name, " valid_wait"}, valid, 1);
  endtask

  task automatic read_byte(input string name);
    wait_valid(name);
    chk({name, " overrun_at_read"}, overrun, 0);
    re = 1'b1;
    @(negedge clock);
    re = 1'b0;
  endtask

  // Monitor: a new byte is a rise of valid or a change of buffer while valid.
  logic       pv = 1'b0;
  logic [7:0] pb = 8'h00;
  always @(negedge clock) begin
    if (valid && (!pv || buffer != pb)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'h0, buffer}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_buffer", buffer, e.d);
        chk("mon_overrun", overrun, e.ovr);
        chk("mon_frameErr", frameErr, e.fe);
      end
    end
    pv = valid;
    pb = buffer;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; uartRxPin = 1'b1; re = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_buffer", buffer, 8'h00);
    chk("reset_valid", valid, 0);
    chk("reset_frameErr", frameErr, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Single byte with exact latency: valid appears after posedge 3+8+144 from the start drive.
    push(8'hA5, 0, 0);
    fork
      send(8'hA5, 0);
      begin
        repeat (154) @(negedge clock);
        chk("single_valid_early", valid, 0);
        @(negedge clock);
        chk("single_valid_on_time", valid, 1);
        chk("single_buffer", buffer, 8'hA5);
        chk("single_frameErr", frameErr, 0);
      end
    join
    re = 1'b1;
    @(negedge clock);
    re = 1'b0;
    chk("single_valid_cleared", valid, 0);
    repeat (10) @(negedge clock);

    // Back-to-back frames with reads in between.
    push(8'h00, 0, 0); push(8'hFF, 0, 0); push(8'h55, 0, 0);
    fork
      begin send(8'h00, 0); send(8'hFF, 0); send(8'h55, 0); end
      begin read_byte("b2b_0"); read_byte("b2b_1"); read_byte("b2b_2"); end
    join
    repeat (10) @(negedge clock);
    chk("b2b_overrun", overrun, 0);

    // Overrun.
    push(8'h12, 0, 0); push(8'h34, 1, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    chk("ovr_buffer", buffer, 8'h34);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", overrun, 1);
    re = 1'b1;
    @(negedge clock);
    re = 1'b0;
    chk("ovr_valid_cleared", valid, 0);
    chk("ovr_flag_cleared", overrun, 0);

    // Framing error with a 3-bit-time break, then a good byte.
    send(8'h3C, 3);
    chk("fe_flag", frameErr, 1);
    chk("fe_valid", valid, 0);
    chk("fe_buffer_kept", buffer, 8'h34);
    push(8'h7E, 0, 1);
    send(8'h7E, 0);
    chk("fe_next_buffer", buffer, 8'h7E);
    re = 1'b1;
    @(negedge clock);
    re = 1'b0;
    chk("fe_cleared", frameErr, 0);
    chk("fe_next_valid_cleared", valid, 0);

    // Glitch shorter than half a bit.
    bit_time(1'b1, 1);
    uartRxPin = 1'b0;
    repeat (4) @(negedge clock);
    uartRxPin = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_valid", valid, 0);
    chk("glitch_frameErr", frameErr, 0);
    chk("glitch_overrun", overrun, 0);
    push(8'h96, 0, 0);
    send(8'h96, 0);
    read_byte("post_glitch");

    // Reset in the middle of data bit 3, with an unread byte pending.
    push(8'h5A, 0, 0);
    send(8'h5A, 0);
    chk("pre_reset_valid", valid, 1);
    fork
      send(8'hC3, 0);
      begin
        repeat (70) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_buffer", buffer, 8'h00);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_frameErr", frameErr, 0);
        chk("async_rst_overrun", overrun, 0);
      end
    join
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("post_rst_valid", valid, 0);
    push(8'h81, 0, 0);
    send(8'h81, 0);
    chk("post_rst_buffer", buffer, 8'h81);
    read_byte("post_rst");

    repeat (10) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
